// File: rtl/crc_pkg.sv
// Shared CRC-9 definitions for the generator and the frame checker.
// Frame layout, generator polynomial, and the checker state type.
package crc_pkg;

  localparam int DATA_W    = 10;
  localparam int CRC_W     = 9;
  localparam int FRAME_LEN = DATA_W + CRC_W;
  localparam int CNT_W     = $clog2(FRAME_LEN);

  // G(x) = x^9 + x^8 + x^7 + x + 1, x^9 implicit
  localparam logic [CRC_W-1:0] POLY = 9'h183;

  typedef enum logic [1:0] {
    IDLE,
    RECV,
    HOLD
  } state_t;

endpackage

// File: rtl/crc9_serial_div.sv
// Bit-serial polynomial divider by POLY, one dividend bit per step.
// Ports: clk, reset, clear (restart at zero), step, bit_in -> rem.
module crc9_serial_div
  import crc_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             step,
  input  logic             bit_in,
  output logic [CRC_W-1:0] rem
);

  logic [CRC_W-1:0] base;
  logic [CRC_W-1:0] nxt;

  // clear and step together: the stepped bit is the first of a new division
  always_comb begin
    base = clear ? '0 : rem;
    nxt  = {base[CRC_W-2:0], bit_in}
         ^ (base[CRC_W-1] ? POLY : '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rem <= '0;
    end else if (step) begin
      rem <= nxt;
    end else if (clear) begin
      rem <= '0;
    end
  end

endmodule

// File: rtl/crc_frame_checker.sv
// Serial CRC-9 frame checker: 10 data bits then 9 CRC bits, MSB first.
// Ports: in_valid/in_ready/in_bit/in_sof in, out_valid/out_ready out.
module crc_frame_checker
  import crc_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_bit,
  input  logic              in_sof,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CRC_W-1:0]  out_syndrome,
  output logic              out_crc_ok,
  output logic              frame_abort
);

  state_t            state;
  state_t            state_n;
  logic [CNT_W-1:0]  count;
  logic [DATA_W-1:0] data_sr;
  logic [CRC_W-1:0]  rem;
  logic              beat;
  logic              start;
  logic              step;
  logic              last;

  crc9_serial_div u_div (
    .clk    (clk),
    .reset  (reset),
    .clear  (start),
    .step   (step),
    .bit_in (in_bit),
    .rem    (rem)
  );

  // No bit is stepped while in HOLD, so the divider keeps the
  // final syndrome there until the next sof.
  assign in_ready     = (state != HOLD) && !reset;
  assign out_valid    = (state == HOLD);
  assign out_syndrome = out_valid ? rem : '0;
  assign out_crc_ok   = out_valid && (rem == '0);

  always_comb begin
    beat    = in_valid && in_ready;
    start   = beat && in_sof;
    step    = beat && (in_sof || state == RECV);
    last    = beat && !in_sof && (state == RECV)
           && (count == CNT_W'(FRAME_LEN - 1));
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = RECV;
      RECV:    if (last) state_n = HOLD;
      HOLD:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // count holds the index of the next bit to be accepted
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      count       <= '0;
      data_sr     <= '0;
      out_data    <= '0;
      frame_abort <= 1'b0;
    end else begin
      state       <= state_n;
      frame_abort <= start && (state == RECV);
      if (start) begin
        count   <= CNT_W'(1);
        data_sr <= {{(DATA_W-1){1'b0}}, in_bit};
      end else if (step) begin
        count <= last ? '0 : count + CNT_W'(1);
        if (count < CNT_W'(DATA_W)) begin
          data_sr <= {data_sr[DATA_W-2:0], in_bit};
        end
      end
      if (last) begin
        out_data <= data_sr;
      end
    end
  end

endmodule

// File: tb/tb_crc_frame_checker.sv
// Self-checking bench for crc_frame_checker.
// Table vectors, corner sequences, random frames vs polynomial model.
module tb_crc_frame_checker;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic       in_bit;
  logic       in_sof;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] out_data;
  logic [8:0] out_syndrome;
  logic       out_crc_ok;
  logic       frame_abort;

  int total = 0;
  int bad   = 0;
  int aborts = 0;

  always #5 clk = ~clk;

  crc_frame_checker dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_bit       (in_bit),
    .in_sof       (in_sof),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_syndrome (out_syndrome),
    .out_crc_ok   (out_crc_ok),
    .frame_abort  (frame_abort)
  );

  always @(posedge clk) if (frame_abort === 1'b1) aborts++;

  typedef struct {
    logic [9:0] data;
    logic [8:0] crc;
    logic [8:0] syn;
    logic       ok;
  } vec_t;

  vec_t tbl [6];

  // remainder of a 19-bit dividend by x^9+x^8+x^7+x+1 (long division)
  function automatic logic [8:0] poly_mod(input logic [18:0] v);
    logic [18:0] t;
    logic [18:0] g;
    t = v;
    g = 19'h383;
    for (int i = 18; i >= 9; i--)
      if (t[i]) t = t ^ (g << (i - 9));
    return t[8:0];
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic send_bit(input logic b, input logic sof, input int ngap);
    bit acc;
    int n;
    repeat (ngap) begin
      in_valid = 1'b0;
      tick();
    end
    in_valid = 1'b1;
    in_bit   = b;
    in_sof   = sof;
    n = 0;
    acc = 1'b0;
    while (!acc && n < 50) begin
      acc = (in_ready === 1'b1);
      tick();
      n++;
    end
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got no in_ready want in_ready");
    end
    in_valid = 1'b0;
    in_sof   = 1'b0;
  endtask

  task automatic send_bits(input logic [18:0] f, input int lo,
                           input int hi, input logic [18:0] gmask,
                           input bit rnd);
    int ng;
    for (int i = lo; i <= hi; i++) begin
      ng = gmask[18-i] ? 1 : 0;
      if (rnd && ($urandom % 4 == 0)) ng = $urandom_range(1, 2);
      send_bit(f[18-i], (i == 0), ng);
    end
  endtask

  task automatic check_result(input string nm, input logic [9:0] d,
                              input logic [8:0] s, input logic ok);
    chk({nm, "_valid"}, out_valid, 1'b1);
    chk({nm, "_data"}, out_data, d);
    chk({nm, "_syn"}, out_syndrome, s);
    chk({nm, "_ok"}, out_crc_ok, ok);
  endtask

  task automatic release_out(input string nm, input int delay);
    repeat (delay) tick();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({nm, "_rel_valid"}, out_valid, 1'b0);
    chk({nm, "_rel_ready"}, in_ready, 1'b1);
  endtask

  initial begin
    logic [18:0] f;
    logic [9:0]  d;
    logic [8:0]  c;
    logic [8:0]  s;
    logic [18:0] gm;
    int          a0;

    tbl[0] = '{10'h001, 9'h183, 9'h000, 1'b1};
    tbl[1] = '{10'h002, 9'h085, 9'h000, 1'b1};
    tbl[2] = '{10'h001, 9'h182, 9'h001, 1'b0};
    tbl[3] = '{10'h004, 9'h10A, 9'h000, 1'b1};
    tbl[4] = '{10'h000, 9'h001, 9'h001, 1'b0};
    tbl[5] = '{10'h001, 9'h000, 9'h183, 1'b0};

    reset = 1'b1; in_valid = 0; in_bit = 0; in_sof = 0; out_ready = 0;
    tick();
    chk("rst_in_ready", in_ready, 1'b0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 10'h0);
    chk("rst_syn", out_syndrome, 9'h0);
    chk("rst_ok", out_crc_ok, 1'b0);
    chk("rst_abort", frame_abort, 1'b0);
    reset = 1'b0;
    #1;
    chk("post_rst_ready", in_ready, 1'b1);

    // non-sof beats in IDLE are dropped
    send_bit(1'b1, 1'b0, 0);
    send_bit(1'b1, 1'b0, 0);

    for (int k = 0; k < 6; k++) begin
      send_bits({tbl[k].data, tbl[k].crc}, 0, 18, '0, 0);
      check_result($sformatf("tbl%0d", k), tbl[k].data,
                   tbl[k].syn, tbl[k].ok);
      release_out($sformatf("tbl%0d", k), 0);
    end

    // three single-cycle gaps, result only after exactly 19 bits
    gm = '0;
    while ($countones(gm) < 3) gm[$urandom_range(0, 18)] = 1'b1;
    f = {10'h002, 9'h085};
    send_bits(f, 0, 17, gm, 0);
    chk("gap_early_valid", out_valid, 1'b0);
    send_bits(f, 18, 18, gm, 0);
    check_result("gap", 10'h002, 9'h000, 1'b1);
    release_out("gap", 0);

    // backpressure: result held, offered bits not consumed
    send_bits({10'h001, 9'h182}, 0, 18, '0, 0);
    in_valid = 1'b1; in_sof = 1'b1; in_bit = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("hold_ready", in_ready, 1'b0);
      check_result("hold", 10'h001, 9'h001, 1'b0);
      tick();
    end
    in_valid = 1'b0; in_sof = 1'b0;
    release_out("hold", 0);

    // abort at bit 7 then a full frame
    a0 = aborts;
    f = {10'h3C5, 9'h0AA};
    send_bits(f, 0, 6, '0, 0);
    f = {10'h001, 9'h183};
    send_bit(f[18], 1'b1, 0);
    chk("abort_pulse", frame_abort, 1'b1);
    tick();
    chk("abort_one_cycle", frame_abort, 1'b0);
    send_bits(f, 1, 18, '0, 0);
    check_result("abort", 10'h001, 9'h000, 1'b1);
    chk("abort_count", aborts - a0, 1);
    release_out("abort", 0);

    // reset mid-frame at bit 12
    a0 = aborts;
    send_bits({10'h155, 9'h1FF}, 0, 11, '0, 0);
    reset = 1'b1;
    tick();
    chk("mid_rst_ready", in_ready, 1'b0);
    chk("mid_rst_valid", out_valid, 1'b0);
    chk("mid_rst_data", out_data, 10'h0);
    reset = 1'b0;
    #1;
    send_bits({10'h002, 9'h085}, 0, 18, '0, 0);
    check_result("post_rst", 10'h002, 9'h000, 1'b1);
    chk("post_rst_no_abort", aborts - a0, 0);

    // reset while holding a result
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("hold_rst_valid", out_valid, 1'b0);
    chk("hold_rst_data", out_data, 10'h0);
    chk("hold_rst_ok", out_crc_ok, 1'b0);
    chk("hold_rst_ready", in_ready, 1'b1);

    // random frames against the division model
    for (int k = 0; k < 40; k++) begin
      d = 10'($urandom_range(0, 1023));
      if ($urandom % 2 == 0) c = poly_mod({d, 9'h000});
      else c = 9'($urandom_range(0, 511));
      s = poly_mod({d, c});
      send_bits({d, c}, 0, 18, '0, 1);
      check_result($sformatf("rnd%0d", k), d, s, (s == 9'h000));
      release_out($sformatf("rnd%0d", k), $urandom_range(0, 3));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
